// File: rtl/spu_issue_ctrl_pkg.sv
// Shared types for the SPU-Lite dual-issue stage: opcodes, pipe/format tags,
// decoded-instruction record and the per-pipe issue payload.
package spu_issue_ctrl_pkg;

  localparam int REG_AW = 7;

  typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_e;

  typedef enum logic [2:0] {RR, RRR, RI7, RI8, RI10, RI16, RI18} fmt_e;

  typedef enum logic [4:0] {
    NOP, LNOP, A, SF, AND, OR, FA, FM, SHLQBI, ROTQBY,
    FMA, SELB, SHUFB, SHLI, ROTI, AI, ANDI, LQD, IL, ILHU, LQA, ILA, CFLTS
  } Opcodes;

  typedef enum logic [1:0] {EMPTY, PAIR, SECOND} issue_state_e;

  // Opcode encodings, grouped by opcode field width.
  localparam logic [10:0] OPC_NOP    = 11'h201;
  localparam logic [10:0] OPC_LNOP   = 11'h001;
  localparam logic [10:0] OPC_A      = 11'h0C0;
  localparam logic [10:0] OPC_SF     = 11'h040;
  localparam logic [10:0] OPC_AND    = 11'h0C1;
  localparam logic [10:0] OPC_OR     = 11'h041;
  localparam logic [10:0] OPC_FA     = 11'h2C4;
  localparam logic [10:0] OPC_FM     = 11'h2C6;
  localparam logic [10:0] OPC_SHLQBI = 11'h1DB;
  localparam logic [10:0] OPC_ROTQBY = 11'h1DC;
  localparam logic [10:0] OPC_SHLI   = 11'h07B;
  localparam logic [10:0] OPC_ROTI   = 11'h078;
  localparam logic [9:0]  OPC_CFLTS  = 10'h1D8;
  localparam logic [8:0]  OPC_IL     = 9'h081;
  localparam logic [8:0]  OPC_ILHU   = 9'h082;
  localparam logic [8:0]  OPC_LQA    = 9'h061;
  localparam logic [7:0]  OPC_AI     = 8'h1C;
  localparam logic [7:0]  OPC_ANDI   = 8'h14;
  localparam logic [7:0]  OPC_LQD    = 8'h34;
  localparam logic [6:0]  OPC_ILA    = 7'h21;
  localparam logic [3:0]  OPC_FMA    = 4'hE;
  localparam logic [3:0]  OPC_SELB   = 4'h8;
  localparam logic [3:0]  OPC_SHUFB  = 4'hB;

  typedef struct packed {
    Opcodes opcode;
    pipe_e  pipe;
    fmt_e   fmt;
    logic   uses_ra;
    logic   uses_rb;
    logic   uses_rc;
    logic   writes_rt;
    logic   illegal;
  } dec_t;

  typedef struct packed {
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic [REG_AW-1:0] rt;
    logic [6:0]        i7;
    logic [7:0]        i8;
    logic [9:0]        i10;
    logic [15:0]       i16;
    logic [17:0]       i18;
  } fields_t;

  typedef struct packed {
    Opcodes  opcode;
    logic    wr_en;
    fields_t f;
  } issue_t;

  // True when any source register of the instruction equals rt.
  // rc is only a source in the three-operand format.
  function automatic logic raw_hit(input dec_t d, input fields_t f,
                                   input logic [REG_AW-1:0] rt);
    return (d.uses_ra && (f.ra == rt)) ||
           (d.uses_rb && (f.rb == rt)) ||
           (d.uses_rc && (d.fmt == RRR) && (f.rc == rt));
  endfunction

  // Payload driven on a pipe that issues nothing this cycle.
  function automatic issue_t idle_issue(input pipe_e p);
    issue_t v;
    v = '0;
    if (p == PIPE_ODD) v.opcode = LNOP;
    else               v.opcode = NOP;
    return v;
  endfunction

  function automatic issue_t make_issue(input dec_t d, input fields_t f);
    issue_t v;
    v.opcode = d.opcode;
    v.wr_en  = d.writes_rt;
    v.f      = f;
    return v;
  endfunction

endpackage

// File: rtl/spu_issue_ctrl_if.sv
// Fetch handshake plus the registered per-pipe issue fields.
// master = fetch/pipes side, slave = issue stage.
interface spu_issue_ctrl_if #(parameter int PAIR_WD = 64);
  import spu_issue_ctrl_pkg::*;

  logic [PAIR_WD-1:0] inst_pair;
  logic               inst_valid;
  logic               inst_ready;
  logic               flush;

  Opcodes     opcode_ep;
  Opcodes     opcode_op;
  logic [6:0] ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [6:0] ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic       rt_wr_en_ep, rt_wr_en_op;
  logic [6:0]  i7_ep,  i7_op;
  logic [7:0]  i8_ep,  i8_op;
  logic [9:0]  i10_ep, i10_op;
  logic [15:0] i16_ep, i16_op;
  logic [17:0] i18_ep, i18_op;
  logic        illegal_op;

  modport master (
    output inst_pair, inst_valid, flush,
    input  inst_ready,
    input  opcode_ep, opcode_op,
    input  ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep,
    input  ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op,
    input  rt_wr_en_ep, rt_wr_en_op,
    input  i7_ep, i7_op, i8_ep, i8_op, i10_ep, i10_op,
    input  i16_ep, i16_op, i18_ep, i18_op,
    input  illegal_op
  );

  modport slave (
    input  inst_pair, inst_valid, flush,
    output inst_ready,
    output opcode_ep, opcode_op,
    output ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep,
    output ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op,
    output rt_wr_en_ep, rt_wr_en_op,
    output i7_ep, i7_op, i8_ep, i8_op, i10_ep, i10_op,
    output i16_ep, i16_op, i18_ep, i18_op,
    output illegal_op
  );
endinterface

// File: rtl/spu_issue_ctrl_decode.sv
// Combinational decode of one 32-bit SPU word: opcode, pipe, format,
// operand usage and raw fields. Fields a format does not carry are zero.
module spu_decode
  import spu_issue_ctrl_pkg::*;
#(
  parameter int INST_WD = 32
) (
  input  logic [INST_WD-1:0] i_word,
  output dec_t               o_dec,
  output fields_t            o_fld
);

  Opcodes w_opc;
  pipe_e  w_pipe;
  fmt_e   w_fmt;
  logic   w_hit;
  logic   w_nop;

  // Opcode match, longest opcode field first so short prefixes cannot steal.
  always_comb begin
    w_opc  = NOP;
    w_pipe = PIPE_EVEN;
    w_fmt  = RR;
    w_hit  = 1'b1;
    case (i_word[31:21])
      OPC_NOP:    w_opc = NOP;
      OPC_LNOP:   begin w_opc = LNOP;   w_pipe = PIPE_ODD; end
      OPC_A:      w_opc = A;
      OPC_SF:     w_opc = SF;
      OPC_AND:    w_opc = AND;
      OPC_OR:     w_opc = OR;
      OPC_FA:     w_opc = FA;
      OPC_FM:     w_opc = FM;
      OPC_SHLQBI: begin w_opc = SHLQBI; w_pipe = PIPE_ODD; end
      OPC_ROTQBY: begin w_opc = ROTQBY; w_pipe = PIPE_ODD; end
      OPC_SHLI:   begin w_opc = SHLI;   w_fmt = RI7; end
      OPC_ROTI:   begin w_opc = ROTI;   w_fmt = RI7; end
      default:    w_hit = 1'b0;
    endcase
    if (!w_hit) begin
      w_hit = 1'b1;
      case (i_word[31:22])
        OPC_CFLTS: begin w_opc = CFLTS; w_fmt = RI8; end
        default:   w_hit = 1'b0;
      endcase
    end
    if (!w_hit) begin
      w_hit = 1'b1;
      case (i_word[31:23])
        OPC_IL:   begin w_opc = IL;   w_fmt = RI16; end
        OPC_ILHU: begin w_opc = ILHU; w_fmt = RI16; end
        OPC_LQA:  begin w_opc = LQA;  w_fmt = RI16; w_pipe = PIPE_ODD; end
        default:  w_hit = 1'b0;
      endcase
    end
    if (!w_hit) begin
      w_hit = 1'b1;
      case (i_word[31:24])
        OPC_AI:   begin w_opc = AI;   w_fmt = RI10; end
        OPC_ANDI: begin w_opc = ANDI; w_fmt = RI10; end
        OPC_LQD:  begin w_opc = LQD;  w_fmt = RI10; w_pipe = PIPE_ODD; end
        default:  w_hit = 1'b0;
      endcase
    end
    if (!w_hit) begin
      w_hit = 1'b1;
      case (i_word[31:25])
        OPC_ILA: begin w_opc = ILA; w_fmt = RI18; end
        default: w_hit = 1'b0;
      endcase
    end
    if (!w_hit) begin
      w_hit = 1'b1;
      case (i_word[31:28])
        OPC_FMA:   begin w_opc = FMA;   w_fmt = RRR; end
        OPC_SELB:  begin w_opc = SELB;  w_fmt = RRR; end
        OPC_SHUFB: begin w_opc = SHUFB; w_fmt = RRR; w_pipe = PIPE_ODD; end
        default:   w_hit = 1'b0;
      endcase
    end
  end

  // Operand usage and field extraction from the matched format.
  always_comb begin
    w_nop           = (w_opc == NOP) || (w_opc == LNOP);
    o_dec           = '0;
    o_dec.opcode    = w_opc;
    o_dec.pipe      = w_pipe;
    o_dec.fmt       = w_fmt;
    o_dec.illegal   = !w_hit;
    o_dec.writes_rt = w_hit && !w_nop;
    o_dec.uses_ra   = w_hit && !w_nop && (w_fmt inside {RR, RRR, RI7, RI8, RI10});
    o_dec.uses_rb   = w_hit && !w_nop && (w_fmt inside {RR, RRR});
    o_dec.uses_rc   = w_hit && (w_fmt == RRR);
    o_fld = '0;
    if (o_dec.uses_ra)   o_fld.ra = i_word[13:7];
    if (o_dec.uses_rb)   o_fld.rb = i_word[20:14];
    if (o_dec.uses_rc)   o_fld.rc = i_word[6:0];
    if (o_dec.writes_rt) o_fld.rt = (w_fmt == RRR) ? i_word[27:21] : i_word[6:0];
    if (w_hit) begin
      case (w_fmt)
        RI7:     o_fld.i7  = i_word[20:14];
        RI8:     o_fld.i8  = i_word[21:14];
        RI10:    o_fld.i10 = i_word[23:14];
        RI16:    o_fld.i16 = i_word[22:7];
        RI18:    o_fld.i18 = i_word[24:7];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spu_issue_ctrl.sv
// Dual-issue decode/issue stage. Buffers one fetch pair, routes each word
// to the even or odd pipe, splits pairs and inserts bubbles on hazards.
// Only the immediately preceding issue is a hazard; older results are
// covered by forwarding.
//
// state  | meaning
// EMPTY  | no buffered instruction, ready for a new pair
// PAIR   | slot0 and slot1 both pending
// SECOND | slot0 issued, slot1 still pending
module spu_issue_ctrl #(
  parameter int INST_WD = 32,
  parameter int PAIR_WD = 2 * INST_WD
) (
  input logic            clk,
  input logic            rst,
  spu_issue_ctrl_if.slave bus
);
  import spu_issue_ctrl_pkg::*;

  issue_state_e       r_state, w_state_nxt;
  logic [INST_WD-1:0] r_slot0, r_slot1;
  logic [PAIR_WD-1:0] w_pair;
  dec_t               w_dec0, w_dec1;
  fields_t            w_fld0, w_fld1;
  issue_t             r_ep, r_op, w_ep_nxt, w_op_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               w_haz0, w_haz1, w_pair_dep, w_rt_clash;
  logic               w_iss0, w_iss1, w_ready, w_accept;

  assign w_pair = bus.inst_pair;

  spu_decode #(.INST_WD(INST_WD)) u_dec0 (.i_word(r_slot0), .o_dec(w_dec0), .o_fld(w_fld0));
  spu_decode #(.INST_WD(INST_WD)) u_dec1 (.i_word(r_slot1), .o_dec(w_dec1), .o_fld(w_fld1));

  assign w_haz0 = (r_ep.wr_en && raw_hit(w_dec0, w_fld0, r_ep.f.rt)) ||
                  (r_op.wr_en && raw_hit(w_dec0, w_fld0, r_op.f.rt));
  assign w_haz1 = (r_ep.wr_en && raw_hit(w_dec1, w_fld1, r_ep.f.rt)) ||
                  (r_op.wr_en && raw_hit(w_dec1, w_fld1, r_op.f.rt));
  assign w_pair_dep = w_dec0.writes_rt && raw_hit(w_dec1, w_fld1, w_fld0.rt);
  assign w_rt_clash = w_dec0.writes_rt && w_dec1.writes_rt && (w_fld0.rt == w_fld1.rt);

  // Decide which buffered slots leave this cycle; flush blocks all issue.
  always_comb begin
    w_iss0 = 1'b0;
    w_iss1 = 1'b0;
    if (!bus.flush) begin
      case (r_state)
        PAIR: begin
          w_iss0 = !w_haz0;
          w_iss1 = w_iss0 && (w_dec0.pipe != w_dec1.pipe) &&
                   !w_pair_dep && !w_rt_clash && !w_haz1;
        end
        SECOND:  w_iss1 = !w_haz1;
        default: ;
      endcase
    end
  end

  assign w_ready = !rst && !bus.flush &&
                   ((r_state == EMPTY) ||
                    ((r_state == PAIR) && w_iss0 && w_iss1) ||
                    ((r_state == SECOND) && w_iss1));
  assign w_accept       = bus.inst_valid && w_ready;
  assign bus.inst_ready = w_ready;

  // Next-state: flush wins, then a new pair (including same-cycle refill).
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = EMPTY;
    end else if (w_accept) begin
      w_state_nxt = PAIR;
    end else begin
      case (r_state)
        PAIR: begin
          if (w_iss0 && w_iss1) w_state_nxt = EMPTY;
          else if (w_iss0)      w_state_nxt = SECOND;
        end
        SECOND:  if (w_iss1) w_state_nxt = EMPTY;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Pair buffer, loaded on every accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (w_accept) begin
      r_slot0 <= w_pair[PAIR_WD-1 -: INST_WD];
      r_slot1 <= w_pair[INST_WD-1:0];
    end
  end

  // Route issuing slots onto their pipe; idle pipes get NOP/LNOP.
  always_comb begin
    w_ep_nxt      = idle_issue(PIPE_EVEN);
    w_op_nxt      = idle_issue(PIPE_ODD);
    w_illegal_nxt = 1'b0;
    if (w_iss0) begin
      if (w_dec0.pipe == PIPE_ODD) w_op_nxt = make_issue(w_dec0, w_fld0);
      else                         w_ep_nxt = make_issue(w_dec0, w_fld0);
      w_illegal_nxt = w_dec0.illegal;
    end
    if (w_iss1) begin
      if (w_dec1.pipe == PIPE_ODD) w_op_nxt = make_issue(w_dec1, w_fld1);
      else                         w_ep_nxt = make_issue(w_dec1, w_fld1);
      w_illegal_nxt = w_illegal_nxt || w_dec1.illegal;
    end
  end

  // Registered pipe-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ep      <= idle_issue(PIPE_EVEN);
      r_op      <= idle_issue(PIPE_ODD);
      r_illegal <= 1'b0;
    end else begin
      r_ep      <= w_ep_nxt;
      r_op      <= w_op_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign bus.opcode_ep   = r_ep.opcode;
  assign bus.ra_addr_ep  = r_ep.f.ra;
  assign bus.rb_addr_ep  = r_ep.f.rb;
  assign bus.rc_addr_ep  = r_ep.f.rc;
  assign bus.rt_addr_ep  = r_ep.f.rt;
  assign bus.rt_wr_en_ep = r_ep.wr_en;
  assign bus.i7_ep       = r_ep.f.i7;
  assign bus.i8_ep       = r_ep.f.i8;
  assign bus.i10_ep      = r_ep.f.i10;
  assign bus.i16_ep      = r_ep.f.i16;
  assign bus.i18_ep      = r_ep.f.i18;

  assign bus.opcode_op   = r_op.opcode;
  assign bus.ra_addr_op  = r_op.f.ra;
  assign bus.rb_addr_op  = r_op.f.rb;
  assign bus.rc_addr_op  = r_op.f.rc;
  assign bus.rt_addr_op  = r_op.f.rt;
  assign bus.rt_wr_en_op = r_op.wr_en;
  assign bus.i7_op       = r_op.f.i7;
  assign bus.i8_op       = r_op.f.i8;
  assign bus.i10_op      = r_op.f.i10;
  assign bus.i16_op      = r_op.f.i16;
  assign bus.i18_op      = r_op.f.i18;

  assign bus.illegal_op  = r_illegal;

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Directed bench for spu_issue_ctrl: dual issue, splits, RAW bubbles,
// illegal words, field formats, flush and mid-pair reset.
module tb_spu_issue_ctrl;
  import spu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  spu_issue_ctrl_if bus ();
  spu_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [10:0] op, input int rt, input int ra, input int rb);
    return {op, 7'(rb), 7'(ra), 7'(rt)};
  endfunction
  function automatic logic [31:0] rrr(input logic [3:0] op, input int rt, input int ra, input int rb, input int rc);
    return {op, 7'(rt), 7'(rb), 7'(ra), 7'(rc)};
  endfunction
  function automatic logic [31:0] ri10(input logic [7:0] op, input int rt, input int ra, input int imm);
    return {op, 10'(imm), 7'(ra), 7'(rt)};
  endfunction
  function automatic logic [31:0] ri16(input logic [8:0] op, input int rt, input int imm);
    return {op, 16'(imm), 7'(rt)};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [63:0] p);
    bus.inst_pair  = p;
    bus.inst_valid = 1'b1;
    #1;
    check("send_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
  endtask

  logic [31:0] w_a3, w_shl5, w_shl5r3, w_fa7, w_lnop, w_ai10, w_lqd11, w_fma, w_lqa;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    w_a3     = rr(11'h0C0, 3, 1, 2);
    w_shl5   = rr(11'h1DB, 5, 4, 6);
    w_shl5r3 = rr(11'h1DB, 5, 3, 6);
    w_fa7    = rr(11'h2C4, 7, 8, 9);
    w_lnop   = 32'h0020_0000;
    w_ai10   = ri10(8'h1C, 10, 3, 5);
    w_lqd11  = ri10(8'h34, 11, 12, 2);
    w_fma    = rrr(4'hE, 20, 21, 22, 23);
    w_lqa    = ri16(9'h061, 30, 16'h0ABC);

    rst = 1'b1;
    bus.inst_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.inst_pair  = '0;
    idle(2);
    check("rst_ready",  32'(bus.inst_ready),  32'd0);
    check("rst_op_ep",  32'(bus.opcode_ep),   32'(NOP));
    check("rst_op_op",  32'(bus.opcode_op),   32'(LNOP));
    check("rst_rt_ep",  32'(bus.rt_addr_ep),  32'd0);
    check("rst_wr_ep",  32'(bus.rt_wr_en_ep), 32'd0);
    check("rst_wr_op",  32'(bus.rt_wr_en_op), 32'd0);
    check("rst_i16_ep", 32'(bus.i16_ep),      32'd0);
    check("rst_ill",    32'(bus.illegal_op),  32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(bus.inst_ready), 32'd1);

    // dual issue
    send({w_a3, w_shl5});
    #1;
    check("dual_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    check("dual_op_ep", 32'(bus.opcode_ep),   32'(A));
    check("dual_rt_ep", 32'(bus.rt_addr_ep),  32'd3);
    check("dual_ra_ep", 32'(bus.ra_addr_ep),  32'd1);
    check("dual_rb_ep", 32'(bus.rb_addr_ep),  32'd2);
    check("dual_op_op", 32'(bus.opcode_op),   32'(SHLQBI));
    check("dual_rt_op", 32'(bus.rt_addr_op),  32'd5);
    check("dual_wr_ep", 32'(bus.rt_wr_en_ep), 32'd1);
    check("dual_wr_op", 32'(bus.rt_wr_en_op), 32'd1);
    idle(1);

    // structural split: both even
    send({w_a3, w_fa7});
    #1;
    check("split_ready0", 32'(bus.inst_ready), 32'd0);
    tick();
    check("split_c1_ep", 32'(bus.opcode_ep),   32'(A));
    check("split_c1_op", 32'(bus.opcode_op),   32'(LNOP));
    check("split_c1_wr", 32'(bus.rt_wr_en_op), 32'd0);
    check("split_ready1", 32'(bus.inst_ready), 32'd1);
    tick();
    check("split_c2_ep", 32'(bus.opcode_ep),  32'(FA));
    check("split_c2_rt", 32'(bus.rt_addr_ep), 32'd7);
    idle(1);

    // intra-pair RAW: shlqbi reads r3 written by a
    send({w_a3, w_shl5r3});
    #1;
    check("iraw_ready0", 32'(bus.inst_ready), 32'd0);
    tick();
    check("iraw_c1_ep", 32'(bus.opcode_ep), 32'(A));
    check("iraw_c1_op", 32'(bus.opcode_op), 32'(LNOP));
    check("iraw_ready1", 32'(bus.inst_ready), 32'd0);
    tick();
    check("iraw_bub_op", 32'(bus.opcode_op),   32'(LNOP));
    check("iraw_bub_wr", 32'(bus.rt_wr_en_op), 32'd0);
    check("iraw_ready2", 32'(bus.inst_ready),  32'd1);
    tick();
    check("iraw_c3_op", 32'(bus.opcode_op),  32'(SHLQBI));
    check("iraw_c3_ra", 32'(bus.ra_addr_op), 32'd3);
    idle(1);

    // cross-pair RAW with same-cycle refill
    send({w_a3, w_lnop});
    send({w_ai10, w_lqd11});
    check("xraw_p1_ep", 32'(bus.opcode_ep), 32'(A));
    check("xraw_ready", 32'(bus.inst_ready), 32'd0);
    tick();
    check("xraw_bub_ep", 32'(bus.opcode_ep),   32'(NOP));
    check("xraw_bub_op", 32'(bus.opcode_op),   32'(LNOP));
    check("xraw_bub_wr", 32'(bus.rt_wr_en_ep), 32'd0);
    tick();
    check("xraw_ep",     32'(bus.opcode_ep),  32'(AI));
    check("xraw_ra_ep",  32'(bus.ra_addr_ep), 32'd3);
    check("xraw_i10_ep", 32'(bus.i10_ep),     32'd5);
    check("xraw_op",     32'(bus.opcode_op),  32'(LQD));
    check("xraw_rt_op",  32'(bus.rt_addr_op), 32'd11);
    check("xraw_ra_op",  32'(bus.ra_addr_op), 32'd12);
    idle(1);

    // illegal word in slot0
    send({32'hFFFF_FFFF, w_shl5});
    tick();
    check("ill_pulse", 32'(bus.illegal_op),  32'd1);
    check("ill_op_ep", 32'(bus.opcode_ep),   32'(NOP));
    check("ill_wr_ep", 32'(bus.rt_wr_en_ep), 32'd0);
    check("ill_op_op", 32'(bus.opcode_op),   32'(SHLQBI));
    tick();
    check("ill_clear", 32'(bus.illegal_op), 32'd0);

    // RRR and RI16 field placement
    send({w_fma, w_lqa});
    tick();
    check("fmt_op_ep",  32'(bus.opcode_ep),  32'(FMA));
    check("fmt_rt_ep",  32'(bus.rt_addr_ep), 32'd20);
    check("fmt_ra_ep",  32'(bus.ra_addr_ep), 32'd21);
    check("fmt_rb_ep",  32'(bus.rb_addr_ep), 32'd22);
    check("fmt_rc_ep",  32'(bus.rc_addr_ep), 32'd23);
    check("fmt_op_op",  32'(bus.opcode_op),  32'(LQA));
    check("fmt_i16_op", 32'(bus.i16_op),     32'h0ABC);
    check("fmt_rt_op",  32'(bus.rt_addr_op), 32'd30);
    check("fmt_ra_op",  32'(bus.ra_addr_op), 32'd0);
    idle(1);

    // flush in SECOND, with a pair offered during the flush
    send({w_a3, w_fa7});
    tick();
    bus.flush      = 1'b1;
    bus.inst_pair  = {w_a3, w_shl5};
    bus.inst_valid = 1'b1;
    #1;
    check("fl_ready", 32'(bus.inst_ready), 32'd0);
    tick();
    bus.flush      = 1'b0;
    bus.inst_valid = 1'b0;
    check("fl_op_ep", 32'(bus.opcode_ep),   32'(NOP));
    check("fl_op_op", 32'(bus.opcode_op),   32'(LNOP));
    check("fl_wr_ep", 32'(bus.rt_wr_en_ep), 32'd0);
    #1;
    check("fl_ready_after", 32'(bus.inst_ready), 32'd1);
    tick();
    check("fl_no_fa", 32'(bus.opcode_ep), 32'(NOP));
    check("fl_no_acc", 32'(bus.opcode_op), 32'(LNOP));

    // reset while a pair is buffered
    send({w_a3, w_shl5});
    send({w_fa7, w_lnop});
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(bus.inst_ready),  32'd0);
    check("mrst_op_ep", 32'(bus.opcode_ep),   32'(NOP));
    check("mrst_rt_ep", 32'(bus.rt_addr_ep),  32'd0);
    check("mrst_wr_op", 32'(bus.rt_wr_en_op), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst_ready_after", 32'(bus.inst_ready), 32'd1);
    tick();
    check("mrst_no_fa", 32'(bus.opcode_ep),   32'(NOP));
    check("mrst_no_wr", 32'(bus.rt_wr_en_ep), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
